// File: rtl/mipi_tx_pkg.sv
// Shared constants for the MIPI TX video packet scheduler.
// CSI/DSI data types and scheduler state encoding.
`timescale 1ns/1ps
package mipi_tx_pkg;

  localparam logic [5:0] DT_FS     = 6'h00;
  localparam logic [5:0] DT_FE     = 6'h01;
  localparam logic [5:0] DT_RGB888 = 6'h3E;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_FS_REQ     = 3'd1;
  localparam logic [2:0] ST_WAIT_LINE  = 3'd2;
  localparam logic [2:0] ST_LP_REQ     = 3'd3;
  localparam logic [2:0] ST_LP_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_GAP        = 3'd5;
  localparam logic [2:0] ST_FE_REQ     = 3'd6;
  localparam logic [2:0] ST_FRAME_GAP  = 3'd7;

endpackage

// File: rtl/mipi_tx_gap_timer.sv
// Loadable 16-bit down-counter; done_o marks the last cycle of a run.
// A load of N yields exactly N running cycles before done.
`timescale 1ns/1ps
module mipi_tx_gap_timer
  import mipi_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        run_i,
  output logic        done_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (run_i && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = run_i && (cnt_q == 16'd1);

endmodule

// File: rtl/mipi_tx_video_scheduler.sv
// Frame packet sequencer: FS, one RGB888 long packet per line, FE.
// Drives the TX core command handshake with registered outputs.
`timescale 1ns/1ps
module mipi_tx_video_scheduler
  import mipi_tx_pkg::*;
#(
  parameter int         H_ACTIVE        = 1280,
  parameter int         V_ACTIVE        = 720,
  parameter int         BYTES_PER_PIXEL = 3,
  parameter int         LINE_GAP        = 16,
  parameter int         FRAME_GAP       = 64,
  parameter logic [1:0] VC              = 2'd0
) (
  input  logic        CLK_tx,
  input  logic        RST,
  input  logic        Enable,
  input  logic        Frame_trig,
  input  logic        Line_ready,
  output logic        Tx_cmd_req,
  output logic [5:0]  Tx_cmd_data_type,
  output logic [15:0] Tx_cmd_word_count,
  output logic [1:0]  Tx_cmd_vc,
  input  logic        Tx_cmd_ack,
  input  logic        Tx_payload_en_last,
  output logic        Busy,
  output logic        Frame_done,
  output logic [15:0] Line_cnt,
  output logic [15:0] Stall_cnt
);

  if (H_ACTIVE * BYTES_PER_PIXEL > 65535) begin : g_bad_wc
    $error("H_ACTIVE*BYTES_PER_PIXEL exceeds 16-bit word count");
  end
  if (LINE_GAP < 1 || FRAME_GAP < 1) begin : g_bad_gap
    $error("LINE_GAP and FRAME_GAP must be at least 1");
  end

  localparam logic [15:0] WC     = 16'(H_ACTIVE * BYTES_PER_PIXEL);
  localparam logic [15:0] LGAP   = 16'(LINE_GAP);
  localparam logic [15:0] FGAP   = 16'(FRAME_GAP);
  localparam logic [15:0] VLINES = 16'(V_ACTIVE);

  logic [2:0]  state_q, state_d, next_q, next_d;
  logic        req_q, req_d, busy_q, done_q, done_d;
  logic [5:0]  dt_q, dt_d;
  logic [15:0] wc_q, wc_d, line_q, line_d, stall_q, stall_d;
  logic        ack_ok, gap_load, gap_run, gap_done;
  logic [15:0] gap_val;

  assign ack_ok = req_q && Tx_cmd_ack;

  assign gap_load = (state_q == ST_FS_REQ && ack_ok)
                 || (state_q == ST_FE_REQ && ack_ok)
                 || (state_q == ST_LP_PAYLOAD && Tx_payload_en_last);
  assign gap_val  = (state_q == ST_FE_REQ) ? FGAP : LGAP;
  assign gap_run  = (state_q == ST_GAP) || (state_q == ST_FRAME_GAP);

  mipi_tx_gap_timer u_gap (
    .clk_i      (CLK_tx),
    .rst_i      (RST),
    .load_i     (gap_load),
    .load_val_i (gap_val),
    .run_i      (gap_run),
    .done_o     (gap_done)
  );

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    req_d   = req_q;
    dt_d    = dt_q;
    wc_d    = wc_q;
    done_d  = 1'b0;
    line_d  = line_q;
    stall_d = stall_q;
    case (state_q)
      ST_IDLE: begin
        if (Frame_trig && Enable) begin
          state_d = ST_FS_REQ;
          req_d   = 1'b1;
          dt_d    = DT_FS;
          wc_d    = 16'd0;
        end
      end
      ST_FS_REQ: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          state_d = ST_GAP;
          next_d  = ST_WAIT_LINE;
          line_d  = 16'd0;
          stall_d = 16'd0;
        end
      end
      ST_WAIT_LINE: begin
        if (Line_ready) begin
          state_d = ST_LP_REQ;
          req_d   = 1'b1;
          dt_d    = DT_RGB888;
          wc_d    = WC;
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      ST_LP_REQ: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          state_d = ST_LP_PAYLOAD;
        end
      end
      ST_LP_PAYLOAD: begin
        if (Tx_payload_en_last) begin
          line_d  = line_q + 16'd1;
          state_d = ST_GAP;
          next_d  = (line_q + 16'd1 == VLINES) ? ST_FE_REQ : ST_WAIT_LINE;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_d = next_q;
          if (next_q == ST_FE_REQ) begin
            req_d = 1'b1;
            dt_d  = DT_FE;
            wc_d  = 16'd0;
          end
        end
      end
      ST_FE_REQ: begin
        if (ack_ok) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FRAME_GAP;
        end
      end
      ST_FRAME_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_tx) begin
    if (RST) begin
      state_q <= ST_IDLE;
      next_q  <= ST_IDLE;
      req_q   <= 1'b0;
      dt_q    <= 6'd0;
      wc_q    <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      line_q  <= 16'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      req_q   <= req_d;
      dt_q    <= dt_d;
      wc_q    <= wc_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      line_q  <= line_d;
      stall_q <= stall_d;
    end
  end

  assign Tx_cmd_req        = req_q;
  assign Tx_cmd_data_type  = dt_q;
  assign Tx_cmd_word_count = wc_q;
  assign Tx_cmd_vc         = VC;
  assign Busy              = busy_q;
  assign Frame_done        = done_q;
  assign Line_cnt          = line_q;
  assign Stall_cnt         = stall_q;

endmodule

// File: tb/tb_mipi_tx_video_scheduler.sv
// Bench for mipi_tx_video_scheduler: TX core responder, frame-level
// command model checked every cycle, plus directed scenarios.
`timescale 1ns/1ps
module tb_mipi_tx_video_scheduler;
  import mipi_tx_pkg::*;

  localparam int HA  = 4;
  localparam int VA  = 2;
  localparam int BPP = 3;
  localparam int LG  = 2;
  localparam int FG  = 4;
  localparam int PAY = 12;
  localparam logic [1:0]  VCH = 2'd1;
  localparam logic [15:0] LWC = 16'd12;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, trig = 1'b0, lr = 1'b0;
  logic ack = 1'b0, last = 1'b0;
  logic req, busy, done;
  logic [5:0]  dt;
  logic [15:0] wc, line, stall;
  logic [1:0]  vc;

  always #5 clk = ~clk;

  mipi_tx_video_scheduler #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .BYTES_PER_PIXEL(BPP),
    .LINE_GAP(LG), .FRAME_GAP(FG), .VC(VCH)
  ) dut (
    .CLK_tx(clk), .RST(rst), .Enable(en), .Frame_trig(trig),
    .Line_ready(lr), .Tx_cmd_req(req), .Tx_cmd_data_type(dt),
    .Tx_cmd_word_count(wc), .Tx_cmd_vc(vc), .Tx_cmd_ack(ack),
    .Tx_payload_en_last(last), .Busy(busy), .Frame_done(done),
    .Line_cnt(line), .Stall_cnt(stall)
  );

  typedef struct packed { logic [5:0] dt; logic [15:0] wc; } cmd_t;
  cmd_t expq[$];
  cmd_t log_q[$];

  int errs = 0, checks = 0;
  bit mbusy, start_pend, done_pend, clr_pend, inc_pend;
  bit acc_prev, req_prev, lr_prev, noise;
  logic [5:0]  dt_prev;
  logic [15:0] wc_prev;
  int fg_left, pay_left, req_age, exp_line, last_hold;
  int idle_run = 1000, ack_delay = 1;
  int frames_done, fs_acks, lp_acks, lp_done;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // TX core responder and frame-level model
  always @(negedge clk) begin
    cmd_t c, e;
    bit exp_done;
    if (rst) begin
      expq.delete();
      mbusy = 0; start_pend = 0; done_pend = 0;
      clr_pend = 0; inc_pend = 0; acc_prev = 0; req_prev = 0;
      fg_left = 0; pay_left = 0; req_age = 0; exp_line = 0;
      ack = 0; last = 0; idle_run = 1000; lr_prev = lr;
    end else begin
      if (start_pend) begin
        chk("trig_to_req", req, 1);
        mbusy = 1;
        start_pend = 0;
      end
      if (clr_pend) exp_line = 0;
      if (inc_pend) exp_line++;
      clr_pend = 0;
      inc_pend = 0;
      exp_done = done_pend;
      done_pend = 0;
      if (fg_left > 0) begin
        fg_left--;
        if (fg_left == 0) mbusy = 0;
      end
      chk("busy", busy, mbusy);
      chk("frame_done", done, exp_done);
      chk("line_cnt", line, exp_line);
      if (done) frames_done++;
      if (acc_prev) chk("req_low_after_ack", req, 0);
      else if (req && req_prev) begin
        chk("dt_stable", dt, dt_prev);
        chk("wc_stable", wc, wc_prev);
      end
      if (req) chk("vc", vc, VCH);
      if (req && !req_prev) begin
        if (dt == DT_RGB888) chk("line_ready_gate", lr_prev, 1);
        if (dt != DT_FS) chk("idle_gap", idle_run >= LG, 1);
      end
      idle_run = req ? 0 : idle_run + 1;
      req_age  = req ? req_age + 1 : 0;
      ack = req ? (req_age == ack_delay + 1) : noise;
      if (pay_left > 0) begin
        pay_left--;
        last = (pay_left == 0);
        if (last) begin
          inc_pend = 1;
          lp_done++;
        end
      end else begin
        last = noise;
      end
      if (req && ack) begin
        c.dt = dt;
        c.wc = wc;
        last_hold = req_age;
        chk("cmd_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("cmd_type", dt, e.dt);
          chk("cmd_wc", wc, e.wc);
        end
        if (dt == DT_FS) begin
          log_q.delete();
          clr_pend = 1;
          fs_acks++;
        end
        log_q.push_back(c);
        if (dt == DT_RGB888) begin
          pay_left = PAY;
          lp_acks++;
        end
        if (dt == DT_FE) begin
          done_pend = 1;
          fg_left = FG + 1;
        end
      end
      acc_prev = req && ack;
      req_prev = req;
      dt_prev  = dt;
      wc_prev  = wc;
      lr_prev  = lr;
      if (trig && en && !mbusy && !start_pend) begin
        start_pend = 1;
        expq.push_back(cmd_t'{dt: DT_FS, wc: 16'd0});
        for (int i = 0; i < VA; i++)
          expq.push_back(cmd_t'{dt: DT_RGB888, wc: LWC});
        expq.push_back(cmd_t'{dt: DT_FE, wc: 16'd0});
      end
    end
  end

  function automatic int cnt_of(input int sel);
    case (sel)
      0:       return frames_done;
      1:       return fs_acks;
      2:       return lp_acks;
      3:       return lp_done;
      default: return mbusy ? 0 : 1;
    endcase
  endfunction

  task automatic wait_ev(input int sel, input int tgt, input string nm);
    int n = 0;
    while (cnt_of(sel) < tgt && n < 600) begin
      @(posedge clk);
      n++;
    end
    chk(nm, cnt_of(sel) >= tgt, 1);
  endtask

  task automatic pulse();
    @(posedge clk); #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
  endtask

  initial begin
    int b, bl;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_dt", dt, 0);
    chk("rst_wc", wc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_line", line, 0);
    chk("rst_stall", stall, 0);

    // basic frame
    @(posedge clk); #1 en = 1'b1; lr = 1'b1;
    pulse();
    wait_ev(0, 1, "s1_frame_timeout");
    wait_ev(4, 1, "s1_idle_timeout");
    chk("s1_ncmd", log_q.size(), 4);
    chk("s1_c0_dt", log_q[0].dt, 8'h00);
    chk("s1_c0_wc", log_q[0].wc, 0);
    chk("s1_c1_dt", log_q[1].dt, 8'h3E);
    chk("s1_c1_wc", log_q[1].wc, 12);
    chk("s1_c2_dt", log_q[2].dt, 8'h3E);
    chk("s1_c2_wc", log_q[2].wc, 12);
    chk("s1_c3_dt", log_q[3].dt, 8'h01);
    chk("s1_c3_wc", log_q[3].wc, 0);
    chk("s1_line", line, 2);
    chk("s1_done_pulses", frames_done, 1);
    chk("s1_stall", stall, 0);
    chk("s1_busy", busy, 0);

    // slow ack
    ack_delay = 5;
    pulse();
    wait_ev(0, 2, "s2_frame_timeout");
    wait_ev(4, 1, "s2_idle_timeout");
    chk("s2_req_hold", last_hold, 6);
    ack_delay = 1;

    // line stall before line 2
    b = lp_done;
    pulse();
    wait_ev(3, b + 1, "s3_line1_timeout");
    #1 lr = 1'b0;
    repeat (LG + 10) @(posedge clk);
    #1 lr = 1'b1;
    wait_ev(0, 3, "s3_frame_timeout");
    chk("s3_stall_at_fe", stall, 10);
    wait_ev(4, 1, "s3_idle_timeout");

    // dropped triggers, noisy ack/last
    noise = 1;
    b = fs_acks;
    bl = lp_acks;
    pulse();
    wait_ev(1, b + 1, "s4_fs_timeout");
    @(negedge clk);
    chk("s4_stall_cleared", stall, 0);
    wait_ev(2, bl + 1, "s4_lp_timeout");
    pulse();
    wait_ev(0, 4, "s4_frame_timeout");
    #1 trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    wait_ev(4, 1, "s4_idle_timeout");
    repeat (8) @(posedge clk);
    #1;
    chk("s4_no_extra_frame", fs_acks, b + 1);
    chk("s4_busy", busy, 0);
    noise = 0;

    // enable dropped mid-frame
    b = fs_acks;
    pulse();
    wait_ev(1, b + 1, "s5_fs_timeout");
    #1 en = 1'b0;
    wait_ev(0, 5, "s5_frame_timeout");
    wait_ev(4, 1, "s5_idle_timeout");
    chk("s5_ncmd", log_q.size(), 4);
    pulse();
    repeat (10) @(posedge clk);
    #1;
    chk("s5_disabled_trig", fs_acks, b + 1);
    chk("s5_busy", busy, 0);

    // reset in payload
    en = 1'b1;
    bl = lp_acks;
    pulse();
    wait_ev(2, bl + 1, "s6_lp_timeout");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("s6_req", req, 0);
    chk("s6_busy", busy, 0);
    chk("s6_line", line, 0);
    b = fs_acks;
    pulse();
    wait_ev(1, b + 1, "s6_fs_timeout");
    chk("s6_first_cmd", log_q[0].dt, 8'h00);
    wait_ev(0, 6, "s6_frame_timeout");
    wait_ev(4, 1, "s6_idle_timeout");
    chk("s6_line_end", line, 2);

    chk("exp_queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/mipi_tx_video_scheduler.md
Name: mipi_tx_video_scheduler

Overview:
Packet sequencer in front of the MIPI CSI/DSI TX core command interface. Per frame it issues Frame Start (00h), then one RGB888 long packet (3Eh) per active line, then Frame End (01h). Each long packet is gated on the pixel FIFO holding a full line. It drives the Tx_cmd_req/ack handshake and tracks payload completion through Tx_payload_en_last, so the downstream FIFO read-enable logic only ever sees well-formed 3Eh packets.

Parameters:
H_ACTIVE, 1280, active pixels per line
V_ACTIVE, 720, active lines per frame
BYTES_PER_PIXEL, 3, bytes per pixel; word count = H_ACTIVE*BYTES_PER_PIXEL, must be ≤65535 (elaboration error otherwise)
LINE_GAP, 16, idle cycles after each packet completes (min 1)
FRAME_GAP, 64, idle cycles after FE ack before the next frame may start (min 1)
VC, 0, 2-bit virtual channel driven on every command

Ports:
CLK_tx  in  1  TX byte clock; the only clock
RST  in  1  synchronous, active-high reset
Enable  in  1  level; allows frames to start
Frame_trig  in  1  single-cycle request to start a frame
Line_ready  in  1  FIFO holds ≥ one full line
Tx_cmd_req  out  1  command request to TX core
Tx_cmd_data_type  out  6  00h FS, 01h FE, 3Eh RGB888
Tx_cmd_word_count  out  16  long packet WC; 0 for short packets
Tx_cmd_vc  out  2  virtual channel (= VC)
Tx_cmd_ack  in  1  TX core accepted command
Tx_payload_en_last  in  1  last payload byte cycle of long packet
Busy  out  1  high whenever state ≠ IDLE
Frame_done  out  1  one-cycle pulse after FE ack
Line_cnt  out  16  lines sent in current frame
Stall_cnt  out  16  saturating count of cycles spent in WAIT_LINE, cleared at FS issue

Behaviour:
- Reset: state IDLE, Tx_cmd_req=0, Tx_cmd_data_type=0, Tx_cmd_word_count=0, Busy=0, Frame_done=0, Line_cnt=0, Stall_cnt=0. Reset mid-packet abandons the packet; req drops at the reset edge.
- All outputs registered.
- Handshake: req rises with stable type/WC. It holds until the first cycle with Tx_cmd_ack=1 while req=1, and is low on the following cycle. Type/WC stay stable while req=1. Ack with req=0 is ignored.
- States:
  - IDLE: on Frame_trig & Enable -> FS_REQ. Frame_trig in any other state is dropped.
  - FS_REQ: type 00h. On ack -> GAP (gap=LINE_GAP, next=WAIT_LINE); Line_cnt=0, Stall_cnt=0.
  - WAIT_LINE: Stall_cnt++ (saturate at FFFFh) each cycle Line_ready=0. When Line_ready=1 -> LP_REQ. No timeout.
  - LP_REQ: type 3Eh, WC=H_ACTIVE*BYTES_PER_PIXEL. On ack -> LP_PAYLOAD.
  - LP_PAYLOAD: req low. On Tx_payload_en_last: Line_cnt++, then -> GAP with next=FE_REQ if Line_cnt+1==V_ACTIVE, else next=WAIT_LINE. Tx_payload_en_last outside LP_PAYLOAD is ignored, including in the same cycle as the ack.
  - GAP: down-counter; after exactly the programmed number of cycles with req=0 -> next.
  - FE_REQ: type 01h. On ack: Frame_done pulse next cycle -> FRAME_GAP.
  - FRAME_GAP: FRAME_GAP cycles -> IDLE. A Frame_trig during FRAME_GAP is not queued.
- Enable deasserted mid-frame: the current frame runs to FE. Enable is sampled only in IDLE.
- Latency: Frame_trig at cycle n -> Tx_cmd_req=1 at n+1.
- Counters: gap counter 16 bits. Line_cnt compare uses the full 16-bit value.

Decomposition:
- Shared package mipi_tx_pkg: data-type constants DT_FS=6'h00, DT_FE=6'h01, DT_RGB888=6'h3E; state enum encoding.
- Optional sub-module mipi_tx_gap_timer: loadable down-counter with done pulse, reused for LINE_GAP and FRAME_GAP.

Test Plan:
- Frame, H_ACTIVE=4, V_ACTIVE=2, BPP=3, LINE_GAP=2, FRAME_GAP=4, Line_ready=1, ack 1 cycle after req, payload_last 12 cycles after ack -> commands in order 00h/WC0, 3Eh/WC12, 3Eh/WC12, 01h/WC0; ≥2 idle cycles between commands; Frame_done pulses once; Line_cnt ends at 2.
- Ack delayed 5 cycles -> req and type/WC held stable all 5 cycles; req low the cycle after ack.
- Line_ready held low 10 cycles before line 2 -> no 3Eh request during those cycles; Stall_cnt=10 at FE; Stall_cnt=0 after the next FS ack.
- Frame_trig pulsed in LP_PAYLOAD and again in FRAME_GAP -> no extra frame; IDLE reached; Busy=0.
- Enable dropped after FS ack -> both lines and FE still sent; a later Frame_trig with Enable=0 gives no req.
- RST asserted in LP_PAYLOAD -> next cycle: req=0, Busy=0, Line_cnt=0. A new Frame_trig then starts a clean FS.
